// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller: opcodes, FSM states,
// datapath mux-select codes and the per-state control word decode.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, ST_MEMWR, ST_EXER,
    ST_EXEI, ST_EXELUI, ST_ALUWB, ST_BEQ, ST_JAL, ST_TRAP
  } state_t;

  localparam logic [1:0] SRC_A_PC      = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC   = 2'b01;
  localparam logic [1:0] SRC_A_RS1     = 2'b10;
  localparam logic [1:0] SRC_B_RS2     = 2'b00;
  localparam logic [1:0] SRC_B_IMM     = 2'b01;
  localparam logic [1:0] SRC_B_FOUR    = 2'b10;
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_OP_LUI    = 2'b11;
  localparam logic [1:0] IMM_I         = 2'b00;
  localparam logic [1:0] IMM_S         = 2'b01;
  localparam logic [1:0] IMM_B         = 2'b10;
  localparam logic [1:0] IMM_J         = 2'b11;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // fetch: ir_write/pc_write gated by mem_ready; branch: pc_write gated by zero.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       illegal;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic [1:0] result_src;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(input state_t st, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_req    = 1'b1;
        c.fetch      = 1'b1;
        c.alu_src_a  = SRC_A_PC;
        c.alu_src_b  = SRC_B_FOUR;
        c.alu_op     = ALU_OP_ADD;
        c.result_src = RES_ALURESULT;
      end
      ST_DECODE: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_OP_ADD;
        c.imm_src   = IMM_B;
      end
      ST_MEMADR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
      end
      ST_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      ST_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      ST_MEMWR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      ST_EXER: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALU_OP_FUNCT;
      end
      ST_EXEI: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_OP_FUNCT;
        c.imm_src   = IMM_I;
      end
      ST_EXELUI: begin
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_OP_LUI;
      end
      ST_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      ST_BEQ: begin
        c.alu_src_a  = SRC_A_RS1;
        c.alu_src_b  = SRC_B_RS2;
        c.alu_op     = ALU_OP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      ST_JAL: begin
        c.alu_src_a  = SRC_A_OLDPC;
        c.alu_src_b  = SRC_B_FOUR;
        c.alu_op     = ALU_OP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
        c.imm_src    = IMM_J;
      end
      ST_TRAP:  c.illegal = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: decode inputs, memory handshake, mux selects,
// enables and performance counters (counters live only with MC_CTRL_PERF_EN).
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_write;
  logic             adr_src;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       imm_src;
  logic [1:0]       result_src;
  logic             illegal_op;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, imm_src, result_src, illegal_op,
           cycle_cnt, instret_cnt
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, imm_src, result_src, illegal_op,
           cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/mc_next_state.sv
// Combinational next-state logic for the multicycle controller FSM.
module mc_next_state
  import riscv_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output state_t     next_state
);

  // NOTE: defaulting every always_comb output first keeps any path from
  // inferring a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:   next_state = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = ST_MEMADR;
          OP_R:         next_state = ST_EXER;
          OP_I:         next_state = ST_EXEI;
          OP_LUI:       next_state = ST_EXELUI;
          OP_BEQ:       next_state = ST_BEQ;
          OP_JAL:       next_state = ST_JAL;
          default:      next_state = ST_TRAP;
        endcase
      end
      ST_MEMADR:  next_state = (op == OP_SW) ? ST_MEMWR : ST_MEMREAD;
      ST_MEMREAD: next_state = mem_ready ? ST_MEMWB : ST_MEMREAD;
      ST_MEMWB:   next_state = ST_FETCH;
      ST_MEMWR:   next_state = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXER, ST_EXEI, ST_EXELUI, ST_JAL: next_state = ST_ALUWB;
      ST_ALUWB:   next_state = ST_FETCH;
      ST_BEQ:     next_state = ST_FETCH;
      ST_TRAP:    next_state = ST_TRAP;
      default:    next_state = ST_TRAP;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-memory multicycle RV32I datapath.
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  mc_next_state u_next_state (
    .state      (state_q),
    .op         (bus.op),
    .mem_ready  (bus.mem_ready),
    .next_state (state_d)
  );

  // The control word is decoded from the next state so it registers alongside it.
  always_comb ctrl_d = ctrl_decode(state_d, bus.op);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ctrl_q  <= ctrl_decode(ST_FETCH, bus.op);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d;
  logic             retire;

  always_comb begin
    retire = (state_q == ST_MEMWB) || (state_q == ST_ALUWB) ||
             (state_q == ST_BEQ) || ((state_q == ST_MEMWR) && bus.mem_ready);
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (state_q != ST_TRAP) begin
      cycle_d = cycle_q + CNT_W'(1);
      if (retire) instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end
`endif

  // Reset forces every output low combinationally, even mid-access.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_write   = 1'b0;
    bus.adr_src     = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.alu_op      = 2'b00;
    bus.imm_src     = 2'b00;
    bus.result_src  = 2'b00;
    bus.illegal_op  = 1'b0;
    bus.cycle_cnt   = {CNT_W{1'b0}};
    bus.instret_cnt = {CNT_W{1'b0}};
    if (!reset) begin
      bus.mem_req    = ctrl_q.mem_req;
      bus.mem_write  = ctrl_q.mem_write;
      bus.adr_src    = ctrl_q.adr_src;
      bus.ir_write   = ctrl_q.fetch & bus.mem_ready;
      bus.pc_write   = (ctrl_q.fetch & bus.mem_ready) | ctrl_q.pc_update |
                       (ctrl_q.branch & bus.zero);
      bus.reg_write  = ctrl_q.reg_write;
      bus.alu_src_a  = ctrl_q.alu_src_a;
      bus.alu_src_b  = ctrl_q.alu_src_b;
      bus.alu_op     = ctrl_q.alu_op;
      bus.imm_src    = ctrl_q.imm_src;
      bus.result_src = ctrl_q.result_src;
      bus.illegal_op = ctrl_q.illegal;
`ifdef MC_CTRL_PERF_EN
      bus.cycle_cnt   = cycle_q;
      bus.instret_cnt = instret_q;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: table-driven instruction runs,
// randomized instruction stream against a per-instruction cycle model, corner cases.
module tb_multicycle_controller;

  localparam int CNT_W = 32;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  // Word layout: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
  //               illegal_op, alu_src_a, alu_src_b, alu_op, imm_src, result_src}
  typedef logic [16:0] word_t;
  localparam word_t W_ZERO       = '0;
  localparam word_t W_FETCH_WAIT = {7'b1000000, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
  localparam word_t W_FETCH_GO   = {7'b1001100, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
  localparam word_t W_DECODE     = {7'b0000000, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
  localparam word_t W_ADR_LW     = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam word_t W_ADR_SW     = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00};
  localparam word_t W_MEMRD      = {7'b1010000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam word_t W_MEMWB      = {7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam word_t W_MEMWR      = {7'b1110000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam word_t W_EXER       = {7'b0000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam word_t W_EXEI       = {7'b0000000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
  localparam word_t W_LUI        = {7'b0000000, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
  localparam word_t W_ALUWB      = {7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam word_t W_BEQ_T      = {7'b0000100, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
  localparam word_t W_BEQ_NT     = {7'b0000000, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
  localparam word_t W_JAL        = {7'b0000100, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00};
  localparam word_t W_TRAP       = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

  typedef struct packed {
    logic  ready;
    logic  zero;
    logic  retire;
    logic  counts;
    word_t exp;
  } step_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic       zero;
    int         fetch_wait;
    int         mem_wait;
    int         cycles;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cyc_ref;
  int   ret_ref;
  step_t q[$];

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic word_t sample();
    return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
            bus.reg_write, bus.illegal_op, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.imm_src, bus.result_src};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic rdy, input logic z, input word_t w,
                               input logic ret, input logic cnt);
    step_t s;
    s.ready = rdy; s.zero = z; s.exp = w; s.retire = ret; s.counts = cnt;
    q.push_back(s);
  endfunction

  // Reference model: the cycle-by-cycle control words an instruction must show,
  // with mem_ready/zero driven only where they matter and random elsewhere.
  task automatic build(input logic [6:0] op, input logic z, input int fw, input int mw);
    q.delete();
    for (int i = 0; i < fw; i++) push(1'b0, rnd(), W_FETCH_WAIT, 1'b0, 1'b1);
    push(1'b1, rnd(), W_FETCH_GO, 1'b0, 1'b1);
    push(rnd(), rnd(), W_DECODE, 1'b0, 1'b1);
    case (op)
      LW: begin
        push(rnd(), rnd(), W_ADR_LW, 1'b0, 1'b1);
        for (int i = 0; i < mw; i++) push(1'b0, rnd(), W_MEMRD, 1'b0, 1'b1);
        push(1'b1, rnd(), W_MEMRD, 1'b0, 1'b1);
        push(rnd(), rnd(), W_MEMWB, 1'b1, 1'b1);
      end
      SW: begin
        push(rnd(), rnd(), W_ADR_SW, 1'b0, 1'b1);
        for (int i = 0; i < mw; i++) push(1'b0, rnd(), W_MEMWR, 1'b0, 1'b1);
        push(1'b1, rnd(), W_MEMWR, 1'b1, 1'b1);
      end
      RT:  begin push(rnd(), rnd(), W_EXER, 1'b0, 1'b1); push(rnd(), rnd(), W_ALUWB, 1'b1, 1'b1); end
      IT:  begin push(rnd(), rnd(), W_EXEI, 1'b0, 1'b1); push(rnd(), rnd(), W_ALUWB, 1'b1, 1'b1); end
      LUI: begin push(rnd(), rnd(), W_LUI, 1'b0, 1'b1);  push(rnd(), rnd(), W_ALUWB, 1'b1, 1'b1); end
      JAL: begin push(rnd(), rnd(), W_JAL, 1'b0, 1'b1);  push(rnd(), rnd(), W_ALUWB, 1'b1, 1'b1); end
      BEQ: push(rnd(), z, z ? W_BEQ_T : W_BEQ_NT, 1'b1, 1'b1);
      default: for (int i = 0; i < 12; i++) push(rnd(), rnd(), W_TRAP, 1'b0, 1'b0);
    endcase
  endtask

  task automatic do_step(input step_t s, input string tag);
    bus.mem_ready = s.ready;
    bus.zero      = s.zero;
    #1;
    check({tag, " word"}, 64'(sample()), 64'(s.exp));
`ifdef MC_CTRL_PERF_EN
    check({tag, " cycle_cnt"}, 64'(bus.cycle_cnt), 64'(cyc_ref));
    check({tag, " instret_cnt"}, 64'(bus.instret_cnt), 64'(ret_ref));
`else
    check({tag, " cycle_cnt tied"}, 64'(bus.cycle_cnt), 64'd0);
    check({tag, " instret_cnt tied"}, 64'(bus.instret_cnt), 64'd0);
`endif
    @(posedge clk);
    if (s.counts) cyc_ref++;
    if (s.retire) ret_ref++;
    @(negedge clk);
  endtask

  task automatic run_q(input string tag);
    foreach (q[i]) do_step(q[i], $sformatf("%s/c%0d", tag, i));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b1;
      bus.mem_ready = 1'b1;
      bus.zero = rnd();
      #1;
      check($sformatf("reset%0d outputs", i), 64'(sample()), 64'(W_ZERO));
      check($sformatf("reset%0d counters", i),
            64'(bus.cycle_cnt) | 64'(bus.instret_cnt), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    cyc_ref = 0;
    ret_ref = 0;
  endtask

  // Measured latency: cycles from the first fetch cycle until the DUT issues
  // the next fetch (ir_write with mem_ready held high), bounded.
  task automatic measure(input string name, input int exp_cycles);
    int n;
    int guard;
    n = q.size();
    guard = 0;
    bus.mem_ready = 1'b1;
    #1;
    while (bus.ir_write !== 1'b1 && guard < 10) begin
      @(posedge clk);
      cyc_ref++;
      @(negedge clk);
      bus.mem_ready = 1'b1;
      #1;
      n++;
      guard++;
    end
    check({name, " latency"}, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    vec_t       tbl[10];
    logic [6:0] ops[7];
    step_t      s;

    tbl[0] = '{"r_type",     RT,  1'b0, 0, 0, 4};
    tbl[1] = '{"lw_wait3",   LW,  1'b0, 0, 3, 8};
    tbl[2] = '{"beq_taken",  BEQ, 1'b1, 0, 0, 3};
    tbl[3] = '{"beq_nt",     BEQ, 1'b0, 0, 0, 3};
    tbl[4] = '{"sw",         SW,  1'b0, 0, 0, 4};
    tbl[5] = '{"i_type",     IT,  1'b0, 0, 0, 4};
    tbl[6] = '{"lui",        LUI, 1'b0, 0, 0, 4};
    tbl[7] = '{"jal",        JAL, 1'b1, 0, 0, 4};
    tbl[8] = '{"lw_fwait1",  LW,  1'b0, 1, 0, 6};
    tbl[9] = '{"sw_fw2_mw1", SW,  1'b1, 2, 1, 7};
    ops = '{LW, SW, RT, IT, BEQ, JAL, LUI};

    n_checks = 0;
    n_fail   = 0;
    cyc_ref  = 0;
    ret_ref  = 0;
    reset    = 1'b1;
    bus.op        = RT;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);

    do_reset(2);

    // lw, sw, R back to back from reset: 5 + 4 + 4 cycles, 3 retires.
    bus.op = LW; build(LW, 1'b0, 0, 0); run_q("perf_lw");
    bus.op = SW; build(SW, 1'b0, 0, 0); run_q("perf_sw");
    bus.op = RT; build(RT, 1'b0, 0, 0); run_q("perf_r");
    #1;
`ifdef MC_CTRL_PERF_EN
    check("perf cycle_cnt", 64'(bus.cycle_cnt), 64'd13);
    check("perf instret_cnt", 64'(bus.instret_cnt), 64'd3);
`else
    check("perf cycle_cnt tied", 64'(bus.cycle_cnt), 64'd0);
    check("perf instret_cnt tied", 64'(bus.instret_cnt), 64'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      bus.op = tbl[i].op;
      build(tbl[i].op, tbl[i].zero, tbl[i].fetch_wait, tbl[i].mem_wait);
      run_q(tbl[i].name);
      measure(tbl[i].name, tbl[i].cycles);
    end

    for (int i = 0; i < 40; i++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 6)];
      bus.op = op;
      build(op, rnd(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      run_q($sformatf("rand%0d_op%02h", i, op));
    end

    // Illegal opcode: trap after decode, sticky flag, counters frozen, reset exits.
    bus.op = BAD;
    build(BAD, 1'b0, 0, 0);
    run_q("trap");
    do_reset(1);
    s = '{ready: 1'b1, zero: 1'b0, retire: 1'b0, counts: 1'b1, exp: W_FETCH_GO};
    do_step(s, "after_trap");

    // Reset during a stalled store drops mem_req/mem_write immediately.
    do_reset(1);
    bus.op = SW;
    q.delete();
    push(1'b1, 1'b0, W_FETCH_GO, 1'b0, 1'b1);
    push(1'b0, 1'b0, W_DECODE, 1'b0, 1'b1);
    push(1'b0, 1'b0, W_ADR_SW, 1'b0, 1'b1);
    push(1'b0, 1'b0, W_MEMWR, 1'b0, 1'b1);
    push(1'b0, 1'b0, W_MEMWR, 1'b0, 1'b1);
    run_q("sw_stall");
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("reset_in_memwr outputs", 64'(sample()), 64'(W_ZERO));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc_ref = 0;
    ret_ref = 0;
    s = '{ready: 1'b1, zero: 1'b0, retire: 1'b0, counts: 1'b1, exp: W_FETCH_GO};
    do_step(s, "after_memwr_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
